// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: one operation in flight, results captured and held.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

package cpu_types_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } aluop_t;
endpackage

module alu_arbiter #(
    parameter int WORD_W = 32
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    req0_valid,
    input  logic                    req1_valid,
    output logic                    req0_ready,
    output logic                    req1_ready,
    input  cpu_types_pkg::aluop_t   req0_op,
    input  cpu_types_pkg::aluop_t   req1_op,
    input  logic [WORD_W-1:0]       req0_a,
    input  logic [WORD_W-1:0]       req0_b,
    input  logic [WORD_W-1:0]       req1_a,
    input  logic [WORD_W-1:0]       req1_b,
    output logic                    rsp0_valid,
    output logic                    rsp1_valid,
    input  logic                    rsp0_ready,
    input  logic                    rsp1_ready,
    output logic [WORD_W-1:0]       rsp_data,
    output logic                    rsp_zero,
    output logic                    rsp_negative,
    output logic                    rsp_overflow,
    output cpu_types_pkg::aluop_t   alu_op,
    output logic [WORD_W-1:0]       alu_a,
    output logic [WORD_W-1:0]       alu_b,
    input  logic [WORD_W-1:0]       alu_out,
    input  logic                    alu_zero,
    input  logic                    alu_negative,
    input  logic                    alu_overflow,
    output logic [1:0]              dbg_state
);
    import cpu_types_pkg::*;

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on anything but the current state, the grant and the valid inputs.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    aluop_t              op_q, op_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                zero_q, zero_d;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic                grant0, grant1;
    logic                rsp_hs;

`ifdef ALU_ARB_RR_EN
    logic                last_q, last_d;

    // last_q remembers who was served most recently; the other side wins a tie.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    assign req0_ready = nRST && (state_q == IDLE) && grant0;
    assign req1_ready = nRST && (state_q == IDLE) && grant1;

    // Ready from the requester is only meaningful while its result is actually offered.
    assign rsp_hs = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        data_d       = data_q;
        zero_d       = zero_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
`ifdef ALU_ARB_RR_EN
        last_d       = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    op_d    = grant1 ? req1_op : req0_op;
                    a_d     = grant1 ? req1_a  : req0_a;
                    b_d     = grant1 ? req1_b  : req0_b;
                    state_d = EXEC;
`ifdef ALU_ARB_RR_EN
                    last_d  = grant1;
`endif
                end
            end
            EXEC: begin
                data_d       = alu_out;
                zero_d       = alu_zero;
                neg_d        = alu_negative;
                ovf_d        = alu_overflow;
                rsp0_valid_d = !owner_q;
                rsp1_valid_d = owner_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            op_q         <= ALU_SLL;
            a_q          <= '0;
            b_q          <= '0;
            data_q       <= '0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            data_q       <= data_d;
            zero_q       <= zero_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
`ifdef ALU_ARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

    // Operand registers only load on acceptance, so the ALU inputs stay quiet otherwise.
    assign alu_op       = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_data     = data_q;
    assign rsp_zero     = zero_q;
    assign rsp_negative = neg_q;
    assign rsp_overflow = ovf_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign dbg_state    = state_q;

endmodule
